// File: rtl/alu_sequencer_if.sv
// Signal bundle between the ALU sequencer, its two requesters, the result consumer and the ALU.
// master = sequencer side, slave = requester/consumer/ALU side.
interface alu_sequencer_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_mode;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_mode;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [7:0]  resp_data;
  logic        resp_zero;
  logic        resp_carry;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_mode;
  logic        alu_ee;
  logic        alu_eo;
  logic [7:0]  alu_bus;
  logic        alu_flag_zero;
  logic        alu_flag_carry;
  logic        bus_busy;
  logic [15:0] op_count;

  modport master (
    input  req0_valid, req0_mode, req0_a, req0_b,
    input  req1_valid, req1_mode, req1_a, req1_b,
    input  resp_ready, alu_bus, alu_flag_zero, alu_flag_carry, bus_busy,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_data, resp_zero, resp_carry,
    output alu_a, alu_b, alu_mode, alu_ee, alu_eo, op_count
  );

  modport slave (
    output req0_valid, req0_mode, req0_a, req0_b,
    output req1_valid, req1_mode, req1_a, req1_b,
    output resp_ready, alu_bus, alu_flag_zero, alu_flag_carry, bus_busy,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_data, resp_zero, resp_carry,
    input  alu_a, alu_b, alu_mode, alu_ee, alu_eo, op_count
  );
endinterface

// File: rtl/alu_sequencer.sv
// Round-robin arbitration of two requesters onto a shared-bus ALU, one operation at a time.
// Optional macro ALU_SEQ_LOCAL_ZERO_EN: resp_zero derived from the captured result, not the ALU flag.
module alu_sequencer (
  input logic             clk,
  input logic             reset,
  alu_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, EXEC, READ, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic [2:0]  mode_q, mode_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  data_q, data_d;
  logic        zero_q, zero_d;
  logic        carry_q, carry_d;
  logic [15:0] count_q, count_d;
  logic        win;
  logic        win_valid;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    count_d = count_q;

    win       = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
    win_valid = win ? bus.req1_valid : bus.req0_valid;

    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_id    = id_q;
    bus.resp_data  = data_q;
    bus.resp_zero  = zero_q;
    bus.resp_carry = carry_q;
    bus.alu_a      = 8'h00;
    bus.alu_b      = 8'h00;
    bus.alu_mode   = 3'b000;
    bus.alu_ee     = 1'b0;
    bus.alu_eo     = 1'b0;
    bus.op_count   = count_q;

    case (state_q)
      IDLE: begin
        bus.req0_ready = ~win & bus.req0_valid;
        bus.req1_ready = win & bus.req1_valid;
        if (win_valid) begin
          last_d  = win;
          id_d    = win;
          mode_d  = win ? bus.req1_mode : bus.req0_mode;
          a_d     = win ? bus.req1_a : bus.req0_a;
          b_d     = win ? bus.req1_b : bus.req0_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        bus.alu_ee   = 1'b1;
        bus.alu_a    = a_q;
        bus.alu_b    = b_q;
        bus.alu_mode = mode_q;
        state_d      = READ;
      end
      READ: begin
        bus.alu_a    = a_q;
        bus.alu_b    = b_q;
        bus.alu_mode = mode_q;
        // The ALU only drives the shared bus once the other master has released it.
        if (!bus.bus_busy) begin
          bus.alu_eo = 1'b1;
          data_d     = bus.alu_bus;
          carry_d    = (mode_q == 3'b011 || mode_q == 3'b100) ? 1'b0 : bus.alu_flag_carry;
`ifdef ALU_SEQ_LOCAL_ZERO_EN
          zero_d     = (bus.alu_bus == 8'h00);
`else
          zero_d     = bus.alu_flag_zero;
`endif
          state_d    = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          count_d = count_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      mode_q  <= 3'b000;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      data_q  <= 8'h00;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      count_q <= count_d;
    end
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port clk  in  1  single system clock; all state updates on posedge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports reqN_valid  in  1  requester N (N=0,1) command valid.
REQ-004 SHALL have ports reqN_ready  out  1  command accepted this cycle.
REQ-005 SHALL have ports reqN_mode  in  3  ALU mode (000 add … 111 xor).
REQ-006 SHALL have ports reqN_a, reqN_b  in  8  operands.
REQ-007 SHALL have port resp_valid  out  1  result available.
REQ-008 SHALL have port resp_ready  in  1  consumer accepts result.
REQ-009 SHALL have port resp_id  out  1  index of the requester that issued the command.
REQ-010 SHALL have ports resp_data  out  8, resp_zero  out  1, resp_carry  out  1: result and flags.
REQ-011 SHALL have ports alu_a, alu_b  out  8 and alu_mode  out  3: ALU operand and mode drive.
REQ-012 SHALL have ports alu_ee, alu_eo  out  1: ALU execute and output enables.
REQ-013 SHALL have port alu_bus  in  8: shared data bus driven by the ALU when alu_eo=1.
REQ-014 SHALL have ports alu_flag_zero, alu_flag_carry  in  1: ALU flag outputs.
REQ-015 SHALL have port bus_busy  in  1: another master owns the bus; READ stalls.
REQ-016 SHALL have port op_count  out  16: completed-operation counter.

Function
REQ-017 SHALL implement FSM IDLE -> EXEC -> READ -> RESP -> IDLE.
REQ-018 IDLE: reqN_ready SHALL be 1 only for the arbitration winner, and only while that requester's valid=1; on handshake, latch mode/a/b/id and go to EXEC.
REQ-019 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it.
REQ-020 EXEC SHALL assert alu_ee=1 for exactly one cycle with latched operands/mode on alu_a/alu_b/alu_mode, then enter READ.
REQ-021 alu_a/alu_b/alu_mode SHALL hold latched values from EXEC through READ.
REQ-022 READ SHALL assert alu_eo=1; while bus_busy=1, hold alu_eo=0 and stay in READ.
REQ-023 READ with bus_busy=0 SHALL capture alu_bus into resp_data, capture flags, and go to RESP.
REQ-024 alu_eo SHALL be 0 in every state other than unstalled READ, which prevents bus contention.
REQ-025 For modes 011/100 (inc/dec), resp_carry SHALL be 0; otherwise resp_carry SHALL equal alu_flag_carry.
REQ-026 RESP SHALL hold resp_valid=1 with stable data/flags/id until resp_ready=1, then go to IDLE next cycle; no new command is accepted in the RESP handshake cycle.
REQ-027 Unstalled latency SHALL be accept at T, alu_ee at T+1, alu_eo at T+2, resp_valid at T+3.
REQ-028 op_count SHALL increment by 1 on each resp handshake and wrap from 0xFFFF to 0x0000.

Reset
REQ-029 On reset=1 at a clock edge, state SHALL become IDLE, whether or not an operation is in progress; an in-flight operation SHALL be dropped with no response.
REQ-030 After reset, all outputs SHALL be 0: ready, resp_*, alu_* and op_count. The last-grant pointer SHALL be set so that req0 wins first.

Configuration
REQ-031 Macro ALU_SEQ_LOCAL_ZERO_EN: when defined, resp_zero SHALL equal (captured resp_data == 0). When undefined, resp_zero SHALL equal alu_flag_zero sampled in READ, which is the ALU's sticky flag.

Verification
REQ-032 req0 add a=0x05 b=0x03 -> alu_ee at T+1, alu_eo at T+2, resp_valid at T+3 with data=0x08, id=0, carry=0, op_count=1.
REQ-033 req0 and req1 both valid from reset -> req0 served first, then req1; with both held valid, grants alternate 0,1,0,1.
REQ-034 bus_busy=1 for 3 cycles during READ -> alu_eo=0 during those cycles, resp_valid delayed by 3, data correct.
REQ-035 req1 add 0xFF+0x01 -> data=0x00, carry=1, zero=1; then xor 0x0F^0x01 -> zero=0 with ALU_SEQ_LOCAL_ZERO_EN defined, zero=1 without it.
REQ-036 resp_ready=0 for 5 cycles -> resp outputs stable and reqN_ready=0 throughout; reset asserted in EXEC -> next cycle IDLE, no resp_valid, op_count=0.
